// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   REG_ADDRESS_LEN : register-address width used across the pipeline
//   hz_state_t      : hazard-controller FSM encoding (RUN / WAIT)
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  localparam int REG_ADDRESS_LEN = 4;

  typedef enum logic {
    HZ_ST_RUN  = 1'b0,
    HZ_ST_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational RAW hazard detector comparing ID-stage sources against the
// destinations still in flight in ID/EX and EX/MEM.
// Build option: PIPE_FORWARDING_EN
//   defined   : a forwarding unit covers ALU results, so only a load in ID/EX
//               feeding the ID instruction (load-use) is a hazard.
//   undefined : any in-flight write to a source register is a hazard.
// Ports:
//   id_src1, id_src1_valid  first source and whether it is read
//   id_src2, id_two_src     second source and whether it is read
//   exe_dest, exe_wb_en, exe_mem_read  ID/EX destination info
//   mem_dest, mem_wb_en     EX/MEM destination info
//   hazard                  a stall is required
// -----------------------------------------------------------------------------
module hazard_detect #(
  parameter int REG_ADDR_W = 4
) (
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_valid,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  hazard
);

  logic match1;
  logic match2;

`ifdef PIPE_FORWARDING_EN
  // With forwarding only a load's data arrives too late to forward, so only
  // a pending load in ID/EX can stall; EX/MEM results are always forwarded.
  logic unused_mem_info;
  assign unused_mem_info = &{1'b0, mem_dest, mem_wb_en};

  assign match1 = exe_mem_read & exe_wb_en & (id_src1 == exe_dest);
  assign match2 = exe_mem_read & exe_wb_en & (id_src2 == exe_dest);
`else
  // Without forwarding every pending writeback in EX or MEM blocks a reader.
  logic unused_load_info;
  assign unused_load_info = &{1'b0, exe_mem_read};

  assign match1 = (exe_wb_en & (id_src1 == exe_dest)) |
                  (mem_wb_en & (id_src1 == mem_dest));
  assign match2 = (exe_wb_en & (id_src2 == exe_dest)) |
                  (mem_wb_en & (id_src2 == mem_dest));
`endif

  assign hazard = (id_src1_valid & match1) | (id_two_src & match2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Pipeline sequencing for the IF/ID and ID/EX registers: stalls on RAW
// hazards, flushes on taken branches, freezes the whole pipe while the data
// SRAM is busy, flags a sticky SRAM timeout and keeps saturating statistics.
// Build option: PIPE_FORWARDING_EN (selects load-use-only hazard detection,
// handled inside hazard_detect).
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   id_src1/id_src2, id_src1_valid/id_two_src   ID-stage sources
//   exe_dest/exe_wb_en/exe_mem_read             ID/EX destination info
//   mem_dest/mem_wb_en       EX/MEM destination info
//   branch_taken             branch resolved taken in EX
//   mem_req, sram_ready      MEM-stage SRAM handshake
//   freeze_if                hold PC and IF/ID (hazard stall)
//   flush_id_ex              bubble into ID/EX (stall or branch)
//   flush_if_id              flush IF/ID (branch)
//   freeze_all               hold every pipeline register (SRAM busy)
//   mem_timeout              sticky SRAM timeout error
//   stall_cnt, flush_cnt     saturating statistics
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDRESS_LEN,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_valid,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  sram_ready,
  output logic                  freeze_if,
  output logic                  flush_id_ex,
  output logic                  flush_if_id,
  output logic                  freeze_all,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  // Wide enough to hold 1..MEM_TIMEOUT.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              freeze_raw;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_src1_valid (id_src1_valid),
    .id_two_src    (id_two_src),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_read  (exe_mem_read),
    .mem_dest      (mem_dest),
    .mem_wb_en     (mem_wb_en),
    .hazard        (hazard)
  );

  // Freeze is decided in the same cycle the SRAM is busy: in RUN a request
  // that is not immediately served freezes at once, and in WAIT the freeze
  // drops in the very cycle the SRAM reports ready.
  always_comb begin
    freeze_raw = 1'b0;
    case (state)
      HZ_ST_RUN:  freeze_raw = mem_req & ~sram_ready;
      HZ_ST_WAIT: freeze_raw = ~sram_ready;
      default:    freeze_raw = 1'b0;
    endcase
  end

  // Control outputs follow priority freeze > branch > hazard. They are gated
  // by rst so every output reads 0 while reset is held, whatever the inputs.
  // A branch arriving during a freeze is held upstream and flushes on the
  // first unfrozen cycle, which falls out of the gating below.
  assign freeze_all  = freeze_raw & ~rst;
  assign flush_if_id = branch_taken & ~freeze_raw & ~rst;
  assign freeze_if   = hazard & ~branch_taken & ~freeze_raw & ~rst;
  assign flush_id_ex = flush_if_id | freeze_if;

  // SRAM wait FSM. wait_cnt counts frozen cycles of the current access,
  // including the RUN cycle that first saw the busy SRAM, so it reaches
  // MEM_TIMEOUT-1 on the MEM_TIMEOUT-th frozen cycle. Once timed out the FSM
  // keeps waiting and the counter holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HZ_ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        HZ_ST_RUN: begin
          if (mem_req && !sram_ready) begin
            state    <= HZ_ST_WAIT;
            wait_cnt <= WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        HZ_ST_WAIT: begin
          if (sram_ready) begin
            state    <= HZ_ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt >= WAIT_LAST) begin
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          state    <= HZ_ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Statistics: one count per stalled cycle and per flushing cycle, holding
  // at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (freeze_if && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_if_id && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl built with CNT_W=4 so counter
// saturation is reachable quickly. Inputs change on the falling edge;
// combinational outputs are sampled 1ns later and counters 1ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int RW    = 4;
  localparam int CW    = 4;
  localparam int MTO   = 64;
`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic          id_src1_valid, id_two_src, exe_wb_en, exe_mem_read;
  logic          mem_wb_en, branch_taken, mem_req, sram_ready;
  logic          freeze_if, flush_id_ex, flush_if_id, freeze_all, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W  (RW),
    .CNT_W       (CW),
    .MEM_TIMEOUT (MTO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_src1       (id_src1),
    .id_src2       (id_src2),
    .id_src1_valid (id_src1_valid),
    .id_two_src    (id_two_src),
    .exe_dest      (exe_dest),
    .exe_wb_en     (exe_wb_en),
    .exe_mem_read  (exe_mem_read),
    .mem_dest      (mem_dest),
    .mem_wb_en     (mem_wb_en),
    .branch_taken  (branch_taken),
    .mem_req       (mem_req),
    .sram_ready    (sram_ready),
    .freeze_if     (freeze_if),
    .flush_id_ex   (flush_id_ex),
    .flush_if_id   (flush_if_id),
    .freeze_all    (freeze_all),
    .mem_timeout   (mem_timeout),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  // 10ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(
    input logic [RW-1:0] s1, input logic s1v, input logic [RW-1:0] s2, input logic two,
    input logic [RW-1:0] ed, input logic ewb, input logic emr,
    input logic [RW-1:0] md, input logic mwb,
    input logic br, input logic mreq, input logic rdy);
    id_src1 = s1;  id_src1_valid = s1v; id_src2 = s2; id_two_src = two;
    exe_dest = ed; exe_wb_en = ewb; exe_mem_read = emr;
    mem_dest = md; mem_wb_en = mwb;
    branch_taken = br; mem_req = mreq; sram_ready = rdy;
  endtask

  task automatic applyIdle();
    applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkControls(input string tag, input logic fi, input logic fie,
                               input logic fii, input logic fa);
    checkOutput({tag, ".freeze_if"},   32'(freeze_if),   32'(fi));
    checkOutput({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fie));
    checkOutput({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fii));
    checkOutput({tag, ".freeze_all"},  32'(freeze_all),  32'(fa));
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
  endtask

  // Present a vector on the falling edge, then let one rising edge pass.
  task automatic driveEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a hazardous, branching, SRAM-busy input pattern: every
    // output must still read 0.
    rst = 1'b1;
    applyStimulus(4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    #2;
    checkControls("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.mem_timeout", 32'(mem_timeout), 32'd0);
    checkCounters("reset");
    @(negedge clk);
    applyIdle();
    rst = 1'b0;
    driveEdge();
    checkCounters("post_reset");

    // RAW hazard on src1 against ID/EX (non-load).
    @(negedge clk);
    applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkControls("raw_exe", !FWD, !FWD, 1'b0, 1'b0);
    driveEdge();
    if (!FWD) exp_stall++;
    checkCounters("raw_exe");

    // RAW hazard on src2 against EX/MEM.
    @(negedge clk);
    applyStimulus(4'd1, 1'b0, 4'd5, 1'b1, 4'd2, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControls("raw_mem", !FWD, !FWD, 1'b0, 1'b0);
    driveEdge();
    if (!FWD) exp_stall++;
    checkCounters("raw_mem");

    // Load-use: stalls in both builds.
    @(negedge clk);
    applyStimulus(4'd9, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkControls("load_use", 1'b1, 1'b1, 1'b0, 1'b0);
    driveEdge();
    exp_stall++;
    checkCounters("load_use");

    // Matching addresses but writeback disabled, and enabled but different
    // addresses: no hazard.
    @(negedge clk);
    applyStimulus(4'd6, 1'b1, 4'd6, 1'b1, 4'd6, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkControls("no_wb", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(4'd6, 1'b1, 4'd7, 1'b1, 4'd8, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkControls("no_match", 1'b0, 1'b0, 1'b0, 1'b0);
    driveEdge();
    checkCounters("no_hazard");

    // Hazard plus taken branch: branch wins.
    @(negedge clk);
    applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkControls("branch", 1'b0, 1'b1, 1'b1, 1'b0);
    driveEdge();
    exp_flush++;
    checkCounters("branch");

    // SRAM busy 5 cycles with hazard and branch held: frozen, nothing counted;
    // on the ready cycle the held branch flushes.
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      checkControls($sformatf("sram_busy%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
      driveEdge();
    end
    checkCounters("sram_busy");
    @(negedge clk);
    applyStimulus(4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    checkControls("sram_ready", 1'b0, 1'b1, 1'b1, 1'b0);
    driveEdge();
    exp_flush++;
    checkCounters("sram_ready");
    // Back in RUN: no request means no freeze even with sram_ready low.
    @(negedge clk);
    applyIdle();
    #1;
    checkControls("back_to_run", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("no_timeout_yet", 32'(mem_timeout), 32'd0);
    driveEdge();

    // Timeout: 64 busy cycles, flag appears at the edge closing cycle 64.
    for (int i = 1; i <= MTO; i++) begin
      @(negedge clk);
      applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      if (i == MTO) checkOutput("timeout_cycle64_pre", 32'(mem_timeout), 32'd0);
      driveEdge();
    end
    checkOutput("timeout_set", 32'(mem_timeout), 32'd1);
    checkOutput("timeout_frozen", 32'(freeze_all), 32'd1);
    @(negedge clk);
    applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    checkOutput("timeout_ready_unfreeze", 32'(freeze_all), 32'd0);
    driveEdge();
    @(negedge clk);
    applyIdle();
    #1;
    checkOutput("timeout_sticky", 32'(mem_timeout), 32'd1);
    checkOutput("timeout_run", 32'(freeze_all), 32'd0);
    driveEdge();

    // Async reset in the middle of WAIT.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      driveEdge();
    end
    #2;
    rst = 1'b1;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    checkOutput("async_rst.freeze_all", 32'(freeze_all), 32'd0);
    checkOutput("async_rst.mem_timeout", 32'(mem_timeout), 32'd0);
    checkCounters("async_rst");
    applyIdle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("after_rst_run", 32'(freeze_all), 32'd0);
    driveEdge();
    @(negedge clk);
    #1;
    checkOutput("after_rst_still_run", 32'(freeze_all), 32'd0);

    // Load-use hazard held 2^CW+3 cycles: stall_cnt saturates at 15.
    for (int i = 1; i <= (1 << CW) + 3; i++) begin
      applyStimulus(4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      driveEdge();
      if (i == 14 || i == 15 || i == 16 || i == (1 << CW) + 3)
        checkOutput($sformatf("sat_stall%0d", i), 32'(stall_cnt), (i < 15) ? i : 15);
      @(negedge clk);
    end
    checkOutput("sat_flush_untouched", 32'(flush_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
